// File: rtl/prog_loader_seq.sv
// Loader/run sequencer in front of the processor core: streams host words into
// instruction memory, releases the core, then times its run until done or timeout.
module prog_loader_seq #(
  parameter int unsigned D    = 12,
  parameter int unsigned W    = 9,
  parameter int unsigned CW   = 16,
  parameter int unsigned TMAX = 4095
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_start,
  input  logic [D-1:0]  ld_len,
  input  logic          in_valid,
  input  logic [W-1:0]  in_data,
  output logic          in_ready,
  output logic          im_wr_en,
  output logic [D-1:0]  im_addr,
  output logic [W-1:0]  im_dat,
  output logic          core_reset,
  output logic          core_req,
  input  logic          core_done,
  output logic          busy,
  output logic          run_done,
  output logic          timeout,
  output logic [CW-1:0] cyc_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_RELEASE, S_RUN, S_DONE, S_TOUT
  } state_t;

  localparam logic [CW-1:0] TMAX_C = CW'(TMAX);

  state_t        state_q, state_d;
  logic [D-1:0]  len_q, len_d;
  logic [D-1:0]  idx_q, idx_d;
  logic          im_wr_en_q, im_wr_en_d;
  logic [D-1:0]  im_addr_q, im_addr_d;
  logic [W-1:0]  im_dat_q, im_dat_d;
  logic          core_req_q, core_req_d;
  logic [CW-1:0] cyc_q, cyc_d;

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    im_wr_en_d = 1'b0;
    im_addr_d  = im_addr_q;
    im_dat_d   = im_dat_q;
    core_req_d = 1'b0;
    cyc_d      = cyc_q;
    case (state_q)
      S_IDLE, S_DONE, S_TOUT: begin
        if (ld_start && (ld_len != '0)) begin
          state_d = S_LOAD;
          len_d   = ld_len;
          idx_d   = '0;
          cyc_d   = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          im_wr_en_d = 1'b1;
          im_addr_d  = idx_q;
          im_dat_d   = in_data;
          idx_d      = idx_q + D'(1);
          if (idx_q == len_q - D'(1)) state_d = S_RELEASE;
        end
      end
      S_RELEASE: begin
        // Registered so the request lands in the first RUN cycle.
        state_d    = S_RUN;
        core_req_d = 1'b1;
      end
      S_RUN: begin
        cyc_d = cyc_q + CW'(1);
        if (core_done)            state_d = S_DONE;
        else if (cyc_d == TMAX_C) state_d = S_TOUT;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      len_q      <= '0;
      idx_q      <= '0;
      im_wr_en_q <= 1'b0;
      im_addr_q  <= '0;
      im_dat_q   <= '0;
      core_req_q <= 1'b0;
      cyc_q      <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      im_wr_en_q <= im_wr_en_d;
      im_addr_q  <= im_addr_d;
      im_dat_q   <= im_dat_d;
      core_req_q <= core_req_d;
      cyc_q      <= cyc_d;
    end
  end

  // Status flags are pure functions of state, so they stay sticky until the next load.
  assign in_ready   = (state_q == S_LOAD);
  assign busy       = (state_q == S_LOAD) || (state_q == S_RELEASE) || (state_q == S_RUN);
  assign core_reset = (state_q != S_RUN);
  assign run_done   = (state_q == S_DONE);
  assign timeout    = (state_q == S_TOUT);
  assign im_wr_en   = im_wr_en_q;
  assign im_addr    = im_addr_q;
  assign im_dat     = im_dat_q;
  assign core_req   = core_req_q;
  assign cyc_count  = cyc_q;

endmodule

// File: tb/tb_prog_loader_seq.sv
// Randomized self-checking bench for prog_loader_seq against a cycle-level
// behavioural model of load, release, run, done and timeout.
module tb_prog_loader_seq;

  localparam int TMAX = 20;

  logic        clk, reset, ld_start, in_valid, core_done;
  logic [11:0] ld_len, im_addr;
  logic [8:0]  in_data, im_dat;
  logic        in_ready, im_wr_en, core_reset, core_req, busy, run_done, timeout;
  logic [15:0] cyc_count;

  int errors = 0;
  int checks = 0;
  int valid_mode;      // 0: always valid, 1: vpat then valid, 2: random
  int vpat[$];
  logic [8:0] dpat[$];

  // {in_ready,im_wr_en,core_reset,core_req,busy,run_done,timeout,im_addr,im_dat,cyc_count}
  localparam logic [43:0] RST_EXP = {7'b0010000, 12'd0, 9'd0, 16'd0};

  prog_loader_seq #(.D(12), .W(9), .CW(16), .TMAX(TMAX)) dut (
    .clk(clk), .reset(reset), .ld_start(ld_start), .ld_len(ld_len),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .im_wr_en(im_wr_en), .im_addr(im_addr), .im_dat(im_dat),
    .core_reset(core_reset), .core_req(core_req), .core_done(core_done),
    .busy(busy), .run_done(run_done), .timeout(timeout), .cyc_count(cyc_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [43:0] obs_all();
    return {in_ready, im_wr_en, core_reset, core_req, busy, run_done, timeout,
            im_addr, im_dat, cyc_count};
  endfunction

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  // Pulses ld_start, then plays the host side until len words are accepted,
  // then checks the release cycle. Ignored ld_start/core_done are injected.
  task automatic do_load(input int len);
    int acc, cyc;
    logic prev_hs;
    logic [11:0] prev_addr;
    logic [8:0] prev_dat, d;
    ld_start = 1'b1; ld_len = 12'(len); in_valid = 1'b0; core_done = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy, in_ready, core_reset} !== 3'b001) begin
      errors++; $display("FAIL pre_load_status: got %b expected 001", {busy, in_ready, core_reset});
    end
    next_cycle();
    ld_start = 1'b0; acc = 0; cyc = 0; prev_hs = 1'b0; prev_addr = '0; prev_dat = '0;
    while (acc < len && cyc < 4 * len + 20) begin
      case (valid_mode)
        0:       in_valid = 1'b1;
        1:       in_valid = (cyc < vpat.size()) ? vpat[cyc][0] : 1'b1;
        default: in_valid = 1'($urandom % 2);
      endcase
      d = (acc < dpat.size()) ? dpat[acc] : 9'($urandom);
      in_data   = d;
      ld_start  = ($urandom % 4) == 0;
      ld_len    = 12'($urandom);
      core_done = 1'($urandom % 2);
      @(negedge clk);
      checks++;
      if ({in_ready, busy, core_reset, core_req, run_done, timeout} !== 6'b111000) begin
        errors++; $display("FAIL load_status: got %b expected 111000",
          {in_ready, busy, core_reset, core_req, run_done, timeout});
      end
      checks++;
      if (cyc_count !== 16'd0) begin
        errors++; $display("FAIL load_cyc_count: got %0d expected 0", cyc_count);
      end
      checks++;
      if (im_wr_en !== prev_hs) begin
        errors++; $display("FAIL load_wr_en: got %b expected %b (cycle %0d)", im_wr_en, prev_hs, cyc);
      end
      if (prev_hs) begin
        checks++;
        if ({im_addr, im_dat} !== {prev_addr, prev_dat}) begin
          errors++; $display("FAIL load_write: got addr %0d dat %h expected addr %0d dat %h",
            im_addr, im_dat, prev_addr, prev_dat);
        end
      end
      prev_hs = in_valid;
      if (in_valid) begin
        prev_addr = 12'(acc); prev_dat = d; acc++;
      end
      next_cycle();
      cyc++;
    end
    checks++;
    if (acc < len) begin
      errors++; $display("FAIL load_bound: accepted %0d expected %0d", acc, len);
    end
    in_valid = 1'($urandom % 2); ld_start = 1'($urandom % 2); core_done = 1'($urandom % 2);
    @(negedge clk);
    checks++;
    if ({in_ready, im_wr_en, busy, core_reset, core_req, im_addr, im_dat} !==
        {5'b01110, prev_addr, prev_dat}) begin
      errors++; $display("FAIL release: got %b/%0d/%h expected 01110/%0d/%h",
        {in_ready, im_wr_en, busy, core_reset, core_req}, im_addr, im_dat, prev_addr, prev_dat);
    end
    next_cycle();
    in_valid = 1'b0; ld_start = 1'b0; core_done = 1'b0;
  endtask

  // Runs the core; done_at is the RUN cycle (1-based) with core_done high,
  // or a value outside 1..TMAX for a run that times out.
  task automatic do_run(input int done_at);
    int n;
    bit fin, exp_done;
    n = 0; fin = 0; exp_done = 0;
    while (!fin) begin
      n++;
      core_done = (n == done_at);
      ld_start  = ($urandom % 3) == 0;
      ld_len    = 12'($urandom);
      in_valid  = 1'($urandom % 2);
      @(negedge clk);
      checks++;
      if ({in_ready, im_wr_en, busy, core_reset, core_req, run_done, timeout} !==
          {4'b0010, (n == 1), 2'b00}) begin
        errors++; $display("FAIL run_status: got %b expected %b (run cycle %0d)",
          {in_ready, im_wr_en, busy, core_reset, core_req, run_done, timeout},
          {4'b0010, (n == 1), 2'b00}, n);
      end
      checks++;
      if (cyc_count !== 16'(n - 1)) begin
        errors++; $display("FAIL run_cyc_count: got %0d expected %0d", cyc_count, n - 1);
      end
      if (n == done_at) begin fin = 1; exp_done = 1; end
      else if (n == TMAX) fin = 1;
      next_cycle();
    end
    ld_start = 1'b0; in_valid = 1'b0; core_done = 1'b1;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({busy, core_reset, core_req, in_ready, run_done, timeout} !==
          {4'b0100, exp_done, !exp_done}) begin
        errors++; $display("FAIL end_status: got %b expected %b",
          {busy, core_reset, core_req, in_ready, run_done, timeout}, {4'b0100, exp_done, !exp_done});
      end
      checks++;
      if (cyc_count !== 16'(n)) begin
        errors++; $display("FAIL end_cyc_count: got %0d expected %0d", cyc_count, n);
      end
      next_cycle();
      core_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; ld_start = 1'b1; ld_len = 12'd5; in_valid = 1'b1; in_data = 9'h1AB; core_done = 1'b1;
    repeat (2) next_cycle();
    @(negedge clk);
    checks++;
    if (obs_all() !== RST_EXP) begin
      errors++; $display("FAIL reset_values: got %h expected %h", obs_all(), RST_EXP);
    end
    reset = 1'b0; ld_start = 1'b0; in_valid = 1'b0; core_done = 1'b0;
    next_cycle();
  endtask

  task automatic test_len_zero();
    ld_start = 1'b1; ld_len = 12'd0;
    next_cycle();
    ld_start = 1'b0;
    repeat (2) begin
      @(negedge clk);
      checks++;
      if ({busy, in_ready, core_reset} !== 3'b001) begin
        errors++; $display("FAIL len_zero_ignored: got %b expected 001", {busy, in_ready, core_reset});
      end
      next_cycle();
    end
  endtask

  task automatic test_fixed_load_and_done();
    valid_mode = 0;
    dpat = '{9'h1A5, 9'h003, 9'h1FF};
    do_load(3);
    dpat = {};
    do_run(10);
  endtask

  task automatic test_gaps_and_timeout();
    valid_mode = 1;
    vpat = '{1, 0, 0, 1, 1, 0, 1};
    do_load(4);
    do_run(0);
  endtask

  task automatic test_back_to_back();
    valid_mode = 2;
    do_load(5);
    do_run(TMAX);
    for (int i = 0; i < 4; i++) begin
      do_load($urandom_range(1, 12));
      do_run($urandom_range(0, TMAX + 4));
    end
  endtask

  task automatic test_max_len();
    valid_mode = 0;
    do_load(4095);
    do_run(1);
  endtask

  task automatic test_reset_mid_load();
    ld_start = 1'b1; ld_len = 12'd5;
    next_cycle();
    ld_start = 1'b0; in_valid = 1'b1;
    repeat (2) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_all() !== RST_EXP) begin
      errors++; $display("FAIL reset_mid_load: got %h expected %h", obs_all(), RST_EXP);
    end
    next_cycle();
    valid_mode = 2;
    do_load(2);
    do_run(3);
  endtask

  task automatic test_reset_mid_run();
    valid_mode = 0;
    do_load(2);
    repeat (4) next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (obs_all() !== RST_EXP) begin
      errors++; $display("FAIL reset_mid_run: got %h expected %h", obs_all(), RST_EXP);
    end
    next_cycle();
  endtask

  initial begin
    reset = 1'b1; ld_start = 1'b0; ld_len = '0; in_valid = 1'b0; in_data = '0; core_done = 1'b0;
    valid_mode = 0;
    test_reset();
    test_len_zero();
    test_fixed_load_and_done();
    test_gaps_and_timeout();
    test_back_to_back();
    test_max_len();
    test_reset_mid_load();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
